// File: rtl/bird_control.sv
// Vertical-motion controller for the player bird: flap edges lift the one-hot
// row, a tick counter drops it by one row every FALL_TICKS cycles, a crash freezes it.
module bird_control #(
    parameter int FALL_TICKS = 8,
    parameter int RISE       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       flap,
    input  logic       crashed,
    output logic [7:0] bird,
    output logic       flying
);

    localparam int CW = $clog2(FALL_TICKS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FLY  = 2'd1;
    localparam logic [1:0] DEAD = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(FALL_TICKS - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          flap_q;
    logic          flap_edge;
    logic [7:0]    up;
    logic [7:0]    down;

    assign flap_edge = flap & ~flap_q;
    assign flying    = (state == FLY);

    // A one-hot row shifted past bit 7 becomes zero, which is clamped to the top row.
    always_comb begin
        up = bird << RISE;
        if (up == '0) begin
            up = 8'h80;
        end
        down = bird[0] ? bird : (bird >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset || !active) begin
            state  <= IDLE;
            bird   <= 8'b0001_0000;
            cnt    <= '0;
            flap_q <= 1'b1;
        end else begin
            flap_q <= flap;
            case (state)
                IDLE: begin
                    if (flap_edge) begin
                        state <= FLY;
                        bird  <= up;
                        cnt   <= '0;
                    end
                end
                FLY: begin
                    if (crashed) begin
                        state <= DEAD;
                    end else if (flap_edge) begin
                        bird <= up;
                        cnt  <= '0;
                    end else if (cnt == LAST) begin
                        cnt  <= '0;
                        bird <= down;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEAD: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
